// File: rtl/stack_ctrl.sv
// Hardware call/data stack controller. It accepts one CPU request at a time,
// drives push/pop strobes to an external negedge-clocked stack, and mirrors
// the stack occupancy. It answers with popped data, jump targets or errors.
module stack_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_vld,
    output logic                            req_rdy,
    input  logic [1:0]                      req_op,
    input  logic [DATA_W-1:0]               req_data,
    output logic                            rsp_vld,
    input  logic                            rsp_rdy,
    output logic [DATA_W-1:0]               rsp_data,
    output logic                            rsp_jmp,
    output logic                            rsp_err,
    output logic                            stk_push,
    output logic                            stk_pop,
    output logic [DATA_W-1:0]               stk_wdata,
    input  logic [DATA_W-1:0]               stk_rdata,
    output logic [$clog2(DEPTH+1)-1:0]      depth,
    output logic                            full,
    output logic                            empty
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Request captured at the accept edge; consumed during ISSUE.
    logic [1:0]          op_p0;
    logic [DATA_W-1:0]   data_p0;

    logic                is_push_op;
    logic                op_ok;

    // A CALL saves the address of the instruction after the call site.
    // The increment wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] return_addr(input logic [DATA_W-1:0] pc);
        return pc + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    assign full  = (depth == DEPTH_W'(DEPTH));
    assign empty = (depth == '0);

    // Classify the latched request and decide whether the stack can take it.
    always_comb begin
        is_push_op = (op_p0 == OP_PUSH) || (op_p0 == OP_CALL);
        op_ok      = is_push_op ? !full : !empty;
    end

    // State register; reset aborts anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus handshake and stack strobes decoded from state.
    always_comb begin
        state_nxt = state;
        req_rdy   = 1'b0;
        rsp_vld   = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_wdata = '0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = RESP;
                if (op_ok) begin
                    if (is_push_op) begin
                        stk_push  = 1'b1;
                        stk_wdata = (op_p0 == OP_CALL) ? return_addr(data_p0) : data_p0;
                    end else begin
                        stk_pop = 1'b1;
                    end
                end
            end
            RESP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request operands on the accept edge.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_vld) begin
            op_p0   <= req_op;
            data_p0 <= req_data;
        end
    end

    // Response fields and the occupancy mirror update at the edge ending ISSUE.
    // The stack pointer moved on the preceding negedge, so stk_rdata already
    // presents the popped word here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_jmp  <= 1'b0;
            rsp_err  <= 1'b0;
            depth    <= '0;
        end else if (state == ISSUE) begin
            rsp_err  <= !op_ok;
            rsp_jmp  <= op_ok && (op_p0 == OP_RET);
            rsp_data <= (op_ok && !is_push_op) ? stk_rdata : '0;
            if (op_ok) begin
                depth <= is_push_op ? depth + 1'b1 : depth - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: a negedge stack memory model, directed scenarios
// and a randomized sequence against a queue-based reference stack.
module tb_stack_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_data;
    logic        rsp_jmp;
    logic        rsp_err;
    logic        stk_push;
    logic        stk_pop;
    logic [31:0] stk_wdata;
    logic [31:0] stk_rdata;
    logic [10:0] depth;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    stack_ctrl #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_data(req_data),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .rsp_jmp(rsp_jmp), .rsp_err(rsp_err),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .depth(depth), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // External 32x1024 stack: write-then-increment on push, decrement on pop,
    // read data is the word at the pointer. Shares rst_n with the controller.
    logic [31:0] mem [0:DEPTH-1];
    logic [10:0] sp;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (stk_push) begin
            mem[sp[9:0]] <= stk_wdata;
            sp <= sp + 11'd1;
        end else if (stk_pop) begin
            sp <= sp - 11'd1;
        end
    end
    assign stk_rdata = mem[sp[9:0]];

    // Strobe monitor: pulse counts, last pushed word, and rule violations.
    int          push_cnt = 0;
    int          pop_cnt  = 0;
    int          viol     = 0;
    logic [31:0] last_wdata = '0;
    always @(negedge clk) begin
        if (stk_push && stk_pop) viol++;
        if (!stk_push && stk_wdata !== 32'd0) viol++;
        if (stk_push) begin
            push_cnt++;
            last_wdata = stk_wdata;
        end
        if (stk_pop) pop_cnt++;
    end

    // Reference stack.
    logic [31:0] model_q[$];

    task automatic model_op(input logic [1:0] op, input logic [31:0] d,
                            output logic [31:0] e_data, output logic e_jmp, output logic e_err,
                            output int e_push, output int e_pop, output logic [31:0] e_wdata);
        e_data = 0; e_jmp = 0; e_err = 0; e_push = 0; e_pop = 0; e_wdata = 0;
        if (op == 2'b00 || op == 2'b10) begin
            if (model_q.size() < DEPTH) begin
                e_wdata = (op == 2'b10) ? d + 32'd1 : d;
                model_q.push_back(e_wdata);
                e_push = 1;
            end else begin
                e_err = 1;
            end
        end else begin
            if (model_q.size() > 0) begin
                e_data = model_q.pop_back();
                e_pop  = 1;
                e_jmp  = (op == 2'b11);
            end else begin
                e_err = 1;
            end
        end
    endtask

    // Present a request, wait for acceptance and then for rsp_vld.
    // Called and returns 1 time unit after a posedge.
    task automatic issue_req(input logic [1:0] op, input logic [31:0] d,
                             output int waits, output int lat, output bit tmo);
        waits = 0; lat = 0; tmo = 0;
        req_vld = 1'b1; req_op = op; req_data = d;
        while (!req_rdy && waits < 50) begin
            @(posedge clk); #1; waits++;
        end
        if (!req_rdy) tmo = 1;
        @(posedge clk); #1;
        req_vld = 1'b0; req_op = 2'($urandom); req_data = $urandom;
        lat = 1;
        while (!rsp_vld && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_vld) tmo = 1;
    endtask

    // Hold off the response for 'dly' cycles, then accept it.
    task automatic finish_rsp(input int dly);
        rsp_rdy = 1'b0;
        repeat (dly) begin @(posedge clk); #1; end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_vld = 1'b0; req_op = 2'b00; req_data = '0; rsp_rdy = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({req_rdy, rsp_vld, full, empty, stk_push, stk_pop, rsp_jmp, rsp_err} !== 8'b1001_0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=10010000",
                     {req_rdy, rsp_vld, full, empty, stk_push, stk_pop, rsp_jmp, rsp_err});
        end
        checks++;
        if (depth !== 11'd0 || rsp_data !== 32'd0 || stk_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_values depth=%0d rsp_data=%h stk_wdata=%h exp=0", depth, rsp_data, stk_wdata);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_q.delete();
    endtask

    task automatic test_push_pop();
        int w, l; bit t; int p0, q0;
        p0 = push_cnt; q0 = pop_cnt;
        issue_req(2'b00, 32'hDEADBEEF, w, l, t);
        checks++;
        if (t || l !== 2 || rsp_err !== 1'b0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL push_rsp tmo=%0d lat=%0d err=%b data=%h exp lat=2 err=0 data=0", t, l, rsp_err, rsp_data);
        end
        finish_rsp(0);
        checks++;
        if (push_cnt - p0 !== 1 || last_wdata !== 32'hDEADBEEF || depth !== 11'd1) begin
            errors++;
            $display("FAIL push_strobe pulses=%0d wdata=%h depth=%0d exp 1/deadbeef/1", push_cnt - p0, last_wdata, depth);
        end
        issue_req(2'b01, 32'h0, w, l, t);
        checks++;
        if (t || l !== 2 || rsp_data !== 32'hDEADBEEF || rsp_err !== 1'b0 || rsp_jmp !== 1'b0) begin
            errors++;
            $display("FAIL pop_rsp lat=%0d data=%h err=%b jmp=%b exp 2/deadbeef/0/0", l, rsp_data, rsp_err, rsp_jmp);
        end
        finish_rsp(0);
        checks++;
        if (pop_cnt - q0 !== 1 || depth !== 11'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL pop_strobe pulses=%0d depth=%0d empty=%b exp 1/0/1", pop_cnt - q0, depth, empty);
        end
    endtask

    task automatic test_call_ret();
        int w, l; bit t;
        issue_req(2'b10, 32'h00000FFF, w, l, t);
        finish_rsp(1);
        checks++;
        if (last_wdata !== 32'h00001000 || rsp_data !== 32'd0 || rsp_jmp !== 1'b0 || depth !== 11'd1) begin
            errors++;
            $display("FAIL call_push wdata=%h data=%h jmp=%b depth=%0d exp 00001000/0/0/1", last_wdata, rsp_data, rsp_jmp, depth);
        end
        issue_req(2'b11, 32'h0, w, l, t);
        checks++;
        if (t || rsp_data !== 32'h00001000 || rsp_jmp !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL ret_rsp data=%h jmp=%b err=%b exp 00001000/1/0", rsp_data, rsp_jmp, rsp_err);
        end
        finish_rsp(0);
        issue_req(2'b10, 32'hFFFFFFFF, w, l, t);
        finish_rsp(0);
        checks++;
        if (last_wdata !== 32'h00000000 || depth !== 11'd1) begin
            errors++;
            $display("FAIL call_wrap wdata=%h depth=%0d exp 00000000/1", last_wdata, depth);
        end
        issue_req(2'b11, 32'h0, w, l, t);
        finish_rsp(0);
        checks++;
        if (depth !== 11'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ret_drain depth=%0d empty=%b exp 0/1", depth, empty);
        end
    endtask

    task automatic test_underflow();
        int w, l; bit t; int q0;
        logic [1:0] ops [2];
        ops[0] = 2'b01; ops[1] = 2'b11;
        for (int k = 0; k < 2; k++) begin
            q0 = pop_cnt;
            issue_req(ops[k], 32'h5555AAAA, w, l, t);
            checks++;
            if (t || rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_jmp !== 1'b0) begin
                errors++;
                $display("FAIL underflow_rsp op=%0d err=%b data=%h jmp=%b exp 1/0/0", ops[k], rsp_err, rsp_data, rsp_jmp);
            end
            finish_rsp(0);
            checks++;
            if (pop_cnt !== q0 || depth !== 11'd0) begin
                errors++;
                $display("FAIL underflow_state op=%0d pops=%0d depth=%0d exp 0/0", ops[k], pop_cnt - q0, depth);
            end
        end
    endtask

    task automatic test_fill_drain();
        int w, l; bit t; int p0;
        for (int i = 0; i < DEPTH; i++) begin
            issue_req(2'b00, 32'(i), w, l, t);
            finish_rsp(0);
            checks++;
            if (t || rsp_err !== 1'b0 || last_wdata !== 32'(i)) begin
                errors++;
                $display("FAIL fill_push i=%0d err=%b wdata=%h", i, rsp_err, last_wdata);
            end
        end
        checks++;
        if (full !== 1'b1 || depth !== 11'd1024 || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full full=%b depth=%0d empty=%b exp 1/1024/0", full, depth, empty);
        end
        for (int k = 0; k < 2; k++) begin
            p0 = push_cnt;
            issue_req(k == 0 ? 2'b00 : 2'b10, 32'hCAFE0000, w, l, t);
            checks++;
            if (t || rsp_err !== 1'b1 || rsp_data !== 32'd0 || rsp_jmp !== 1'b0) begin
                errors++;
                $display("FAIL overflow_rsp k=%0d err=%b data=%h jmp=%b exp 1/0/0", k, rsp_err, rsp_data, rsp_jmp);
            end
            finish_rsp(0);
            checks++;
            if (push_cnt !== p0 || depth !== 11'd1024) begin
                errors++;
                $display("FAIL overflow_state k=%0d pushes=%0d depth=%0d exp 0/1024", k, push_cnt - p0, depth);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            issue_req(2'b01, 32'h0, w, l, t);
            checks++;
            if (t || rsp_err !== 1'b0 || rsp_data !== 32'(i)) begin
                errors++;
                $display("FAIL drain_pop exp=%0d got=%0d err=%b", i, rsp_data, rsp_err);
            end
            finish_rsp(0);
        end
        checks++;
        if (empty !== 1'b1 || depth !== 11'd0 || full !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty empty=%b depth=%0d full=%b exp 1/0/0", empty, depth, full);
        end
    endtask

    task automatic test_backpressure();
        int w, l; bit t; int p0;
        issue_req(2'b00, 32'h12345678, w, l, t);
        finish_rsp(0);
        issue_req(2'b01, 32'h0, w, l, t);
        p0 = push_cnt;
        req_vld = 1'b1; req_op = 2'b00; req_data = 32'h0BADF00D;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_vld !== 1'b1 || rsp_data !== 32'h12345678 || req_rdy !== 1'b0 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d vld=%b data=%h rdy=%b err=%b exp 1/12345678/0/0", c, rsp_vld, rsp_data, req_rdy, rsp_err);
            end
        end
        req_vld = 1'b0;
        finish_rsp(0);
        checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b1 || push_cnt !== p0 || depth !== 11'd0) begin
            errors++;
            $display("FAIL bp_release vld=%b rdy=%b pushes=%0d depth=%0d exp 0/1/0/0", rsp_vld, req_rdy, push_cnt - p0, depth);
        end
    endtask

    task automatic test_reset_in_flight();
        int w, l; bit t;
        issue_req(2'b00, 32'hA5A5A5A5, w, l, t);
        finish_rsp(0);
        req_vld = 1'b1; req_op = 2'b00; req_data = 32'h11112222;
        @(posedge clk); #1;
        req_vld = 1'b0;
        checks++;
        if (stk_push !== 1'b1) begin
            errors++;
            $display("FAIL rif_issue stk_push=%b exp 1", stk_push);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b1 || depth !== 11'd0 || stk_push !== 1'b0 || rsp_vld !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rif_abort rdy=%b depth=%0d push=%b vld=%b empty=%b exp 1/0/0/0/1",
                     req_rdy, depth, stk_push, rsp_vld, empty);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_vld !== 1'b0) begin
                errors++;
                $display("FAIL rif_norsp c=%0d rsp_vld=%b exp 0", c, rsp_vld);
            end
        end
        rst_n = 1'b1;
        model_q.delete();
        issue_req(2'b01, 32'h0, w, l, t);
        checks++;
        if (t || w !== 0 || l !== 2 || rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL rif_first waits=%0d lat=%0d err=%b data=%h exp 0/2/1/0", w, l, rsp_err, rsp_data);
        end
        finish_rsp(0);
    endtask

    task automatic test_random();
        int w, l; bit t; int p0, q0;
        logic [1:0] op; logic [31:0] d;
        logic [31:0] e_data, e_wdata; logic e_jmp, e_err; int e_push, e_pop;
        for (int n = 0; n < 400; n++) begin
            op = 2'($urandom_range(0, 3));
            d  = (n % 17 == 0) ? 32'hFFFFFFFF : $urandom;
            model_op(op, d, e_data, e_jmp, e_err, e_push, e_pop, e_wdata);
            p0 = push_cnt; q0 = pop_cnt;
            issue_req(op, d, w, l, t);
            checks++;
            if (t || l !== 2 || rsp_data !== e_data || rsp_jmp !== e_jmp || rsp_err !== e_err) begin
                errors++;
                $display("FAIL rand_rsp n=%0d op=%0d lat=%0d got %h/%b/%b exp %h/%b/%b",
                         n, op, l, rsp_data, rsp_jmp, rsp_err, e_data, e_jmp, e_err);
            end
            finish_rsp($urandom_range(0, 3));
            checks++;
            if (push_cnt - p0 !== e_push || pop_cnt - q0 !== e_pop ||
                (e_push == 1 && last_wdata !== e_wdata) || depth !== 11'(model_q.size())) begin
                errors++;
                $display("FAIL rand_stack n=%0d op=%0d push=%0d pop=%0d wdata=%h depth=%0d exp %0d/%0d/%h/%0d",
                         n, op, push_cnt - p0, pop_cnt - q0, last_wdata, depth, e_push, e_pop, e_wdata, model_q.size());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_call_ret();
        test_underflow();
        test_fill_drain();
        test_backpressure();
        test_reset_in_flight();
        test_random();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL strobe_rules violations=%0d exp 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
